// File: rtl/rsa_mont_exp.sv
// Modular exponentiation controller: right-to-left square-and-multiply over an
// external Montgomery multiplier reached through valid/ready request/response ports.
module rsa_mont_exp #(
  parameter int MOD_WIDTH = 256,
  parameter int EXP_WIDTH = 256,
  localparam int LW = $clog2(EXP_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [MOD_WIDTH-1:0] i_base,
  input  logic [MOD_WIDTH-1:0] i_msg,
  input  logic [EXP_WIDTH-1:0] i_key,
  input  logic [LW-1:0]        i_exp_len,
  input  logic [MOD_WIDTH-1:0] i_modulus,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [MOD_WIDTH-1:0] o_crypto,
  output logic [LW:0]          o_op_count,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [MOD_WIDTH-1:0] m_a,
  output logic [MOD_WIDTH-1:0] m_b,
  output logic [MOD_WIDTH-1:0] m_mod,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [MOD_WIDTH-1:0] r_out
);
  // state | meaning
  // IDLE  | waiting for a job, i_ready high
  // PACK  | S = mont(base, msg): message into the Montgomery domain
  // MUL   | M = mont(S, M)
  // SQR   | S = mont(S, S), then bit index advances
  // DONE  | result presented until o_ready
  typedef enum logic [2:0] {IDLE, PACK, MUL, SQR, DONE} state_t;

  localparam logic [LW-1:0] EXP_MAX = LW'(EXP_WIDTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  state_t               state, state_n;
  logic                 wait_ph, wait_n;
  logic [MOD_WIDTH-1:0] s_reg, m_reg, base_q, msg_q, mod_q;
  logic [EXP_WIDTH-1:0] key_q;
  logic [LW-1:0]        len_q, k_q, k_eval, len_in;
  logic [LW:0]          op_cnt;
  logic                 key_bit, last;
  state_t               next_op;

  assign len_in = (i_exp_len > EXP_MAX) ? EXP_MAX : i_exp_len;

  // A finishing SQR decides on the bit it is about to advance to.
  assign k_eval  = (state == SQR) ? k_q + ONE_L : k_q;
  assign key_bit = |(key_q & (EXP_WIDTH'(1) << k_eval));
  assign last    = (k_eval == len_q - ONE_L);

  assign o_crypto   = m_reg;
  assign o_op_count = op_cnt;
  assign m_mod      = mod_q;

  always_comb begin
    m_a = s_reg;
    m_b = s_reg;
    if (state == PACK) begin
      m_a = base_q;
      m_b = msg_q;
    end else if (state == MUL) begin
      m_b = m_reg;
    end
  end

  always_comb begin
    next_op = DONE;
    if (state == MUL) next_op = last ? DONE : SQR;
    else if (key_bit) next_op = MUL;
    else if (!last)   next_op = SQR;
  end

  always_comb begin
    state_n = state;
    wait_n  = wait_ph;
    i_ready = 1'b0;
    o_valid = 1'b0;
    m_valid = 1'b0;
    r_ready = 1'b0;
    case (state)
      IDLE: begin
        i_ready = 1'b1;
        if (i_valid) begin
          wait_n  = 1'b0;
          state_n = (len_in == '0) ? DONE : PACK;
        end
      end
      PACK, MUL, SQR: begin
        if (!wait_ph) begin
          m_valid = 1'b1;
          if (m_ready) wait_n = 1'b1;
        end else begin
          r_ready = 1'b1;
          if (r_valid) begin
            wait_n  = 1'b0;
            state_n = next_op;
          end
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (o_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wait_ph <= 1'b0;
      s_reg   <= '0;
      m_reg   <= '0;
      base_q  <= '0;
      msg_q   <= '0;
      mod_q   <= '0;
      key_q   <= '0;
      len_q   <= '0;
      k_q     <= '0;
      op_cnt  <= '0;
    end else begin
      state   <= state_n;
      wait_ph <= wait_n;
      if (i_valid && i_ready) begin
        base_q <= i_base;
        msg_q  <= i_msg;
        mod_q  <= i_modulus;
        key_q  <= i_key;
        len_q  <= len_in;
        m_reg  <= MOD_WIDTH'(1);
        k_q    <= '0;
        op_cnt <= '0;
      end
      if (m_valid && m_ready) op_cnt <= op_cnt + 1'b1;
      if (r_valid && r_ready) begin
        case (state)
          PACK: s_reg <= r_out;
          MUL:  m_reg <= r_out;
          SQR: begin
            s_reg <= r_out;
            k_q   <= k_eval;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rsa_mont_exp.sv
// Bench for rsa_mont_exp: 3-cycle Montgomery multiplier model, reference modpow
// and per-scenario checks including backpressure, clamping and mid-job reset.
module tb_rsa_mont_exp;
  localparam int MW = 8;
  localparam int EW = 8;
  localparam int LW = $clog2(EW + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid, i_ready;
  logic [MW-1:0] i_base, i_msg, i_modulus;
  logic [EW-1:0] i_key;
  logic [LW-1:0] i_exp_len;
  logic          o_valid, o_ready;
  logic [MW-1:0] o_crypto;
  logic [LW:0]   o_op_count;
  logic          m_valid, m_ready;
  logic [MW-1:0] m_a, m_b, m_mod;
  logic          r_valid, r_ready;
  logic [MW-1:0] r_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cur_n   = 197;
  int m_stall = 0;
  int mv_cycles = 0;
  int log_a[$];
  int log_b[$];

  always #5 clk = ~clk;

  rsa_mont_exp #(.MOD_WIDTH(MW), .EXP_WIDTH(EW)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_base(i_base), .i_msg(i_msg), .i_key(i_key), .i_exp_len(i_exp_len),
    .i_modulus(i_modulus),
    .o_valid(o_valid), .o_ready(o_ready), .o_crypto(o_crypto), .o_op_count(o_op_count),
    .m_valid(m_valid), .m_ready(m_ready), .m_a(m_a), .m_b(m_b), .m_mod(m_mod),
    .r_valid(r_valid), .r_ready(r_ready), .r_out(r_out)
  );

  function automatic int rinv_of(int n);
    for (int x = 1; x < n; x++) if ((256 * x) % n == 1) return x;
    return 0;
  endfunction

  function automatic int mont(int a, int b, int n);
    return (((a * b) % n) * rinv_of(n)) % n;
  endfunction

  function automatic int eff_key(int key, int len);
    int l = (len > EW) ? EW : len;
    return key & ((1 << l) - 1);
  endfunction

  function automatic int modpow(int msg, int e, int n);
    int r = 1 % n;
    for (int i = 0; i < e; i++) r = (r * msg) % n;
    return r;
  endfunction

  function automatic int exp_ops(int key, int len);
    int l = (len > EW) ? EW : len;
    if (l == 0) return 0;
    return 1 + $countones(eff_key(key, len)) + (l - 1);
  endfunction

  // Multiplier model: accepts one request, answers 3 cycles later.
  initial begin : mult_model
    bit busy, m_fire, r_fire;
    int lat, res;
    busy = 0; m_fire = 0; r_fire = 0; lat = 0; res = 0;
    m_ready = 1'b0; r_valid = 1'b0; r_out = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0; m_fire = 0; r_fire = 0;
        r_valid = 1'b0; m_ready = 1'b0;
        continue;
      end
      if (m_valid) mv_cycles++;
      if (r_fire) begin r_valid = 1'b0; busy = 0; r_fire = 0; end
      if (m_fire) begin busy = 1; lat = 3; m_fire = 0; end
      if (busy && !r_valid) begin
        lat--;
        if (lat == 0) begin r_valid = 1'b1; r_out = MW'(res); end
      end
      if (m_stall > 0 && m_valid) begin
        m_ready = 1'b0;
        m_stall--;
      end else begin
        m_ready = !busy;
      end
      if (m_valid && m_ready) begin
        m_fire = 1;
        res = mont(int'(m_a), int'(m_b), cur_n);
        log_a.push_back(int'(m_a));
        log_b.push_back(int'(m_b));
      end
      if (r_valid && r_ready) r_fire = 1;
    end
  end

  task automatic start_job(input int base, input int msg, input int key, input int len, input int n);
    @(negedge clk);
    cur_n = n;
    i_base = MW'(base); i_msg = MW'(msg); i_key = EW'(key);
    i_exp_len = LW'(len); i_modulus = MW'(n); i_valid = 1'b1;
    for (int w = 0; w < 50 && !i_ready; w++) @(negedge clk);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_result(output int crypto, output int cnt, output bit ok);
    ok = 0;
    for (int w = 0; w < 3000; w++) begin
      if (o_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    crypto = int'(o_crypto);
    cnt = int'(o_op_count);
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({i_ready, o_valid, m_valid, r_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 1000", {i_ready, o_valid, m_valid, r_ready});
    end
    n_tests++;
    if ({o_crypto, o_op_count, m_a, m_b, m_mod} !== '0) begin
      n_fail++;
      $display("FAIL reset_data crypto=%0d cnt=%0d a=%0d b=%0d mod=%0d want all 0",
               o_crypto, o_op_count, m_a, m_b, m_mod);
    end
  endtask

  task automatic test_basic();
    int c, k; bit ok;
    start_job(132, 5, 3, 2, 197);
    n_tests++;
    if (m_valid !== 1'b1) begin n_fail++; $display("FAIL accept_to_mvalid got %b want 1", m_valid); end
    wait_result(c, k, ok);
    n_tests++;
    if (!ok || c != 125) begin n_fail++; $display("FAIL basic_crypto got %0d (ok=%0d) want 125", c, ok); end
    n_tests++;
    if (k != 4) begin n_fail++; $display("FAIL basic_opcount got %0d want 4", k); end
    n_tests++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL done_to_idle i_ready=%b o_valid=%b want 1/0", i_ready, o_valid);
    end
  endtask

  task automatic test_op_order();
    int c, k, s, m; bit ok;
    int ea[$];
    int eb[$];
    log_a.delete(); log_b.delete();
    s = mont(132, 5, 197); m = 1;
    ea.push_back(132); eb.push_back(5);
    for (int i = 0; i < 4; i++) begin
      if ((8'h0D >> i) & 1) begin ea.push_back(s); eb.push_back(m); m = mont(s, m, 197); end
      if (i < 3) begin ea.push_back(s); eb.push_back(s); s = mont(s, s, 197); end
    end
    start_job(132, 5, 8'h0D, 4, 197);
    wait_result(c, k, ok);
    n_tests++;
    if (!ok || c != 111) begin n_fail++; $display("FAIL order_crypto got %0d want 111", c); end
    n_tests++;
    if (k != 7) begin n_fail++; $display("FAIL order_opcount got %0d want 7", k); end
    n_tests++;
    if (log_a.size() != ea.size()) begin
      n_fail++; $display("FAIL order_len got %0d want %0d", log_a.size(), ea.size());
    end else begin
      for (int i = 0; i < ea.size(); i++) begin
        n_tests++;
        if (log_a[i] != ea[i] || log_b[i] != eb[i]) begin
          n_fail++;
          $display("FAIL order_op%0d got (%0d,%0d) want (%0d,%0d)", i, log_a[i], log_b[i], ea[i], eb[i]);
        end
      end
    end
    n_tests++;
    if (m_mod !== 8'd197) begin n_fail++; $display("FAIL m_mod got %0d want 197", m_mod); end
  endtask

  task automatic test_clamp();
    int c, k, want; bit ok;
    start_job(132, 5, 8'hFD, 4, 197);
    wait_result(c, k, ok);
    n_tests++;
    if (!ok || c != 111 || k != 7) begin
      n_fail++; $display("FAIL ignore_high_bits got %0d/%0d want 111/7", c, k);
    end
    want = modpow(5, eff_key(8'hFD, 15), 197);
    start_job(132, 5, 8'hFD, 15, 197);
    wait_result(c, k, ok);
    n_tests++;
    if (!ok || c != want || k != exp_ops(8'hFD, 15)) begin
      n_fail++; $display("FAIL clamp_len got %0d/%0d want %0d/%0d", c, k, want, exp_ops(8'hFD, 15));
    end
  endtask

  task automatic test_len_zero();
    int c, k, mv0; bit ok;
    mv0 = mv_cycles;
    start_job(132, 5, 8'hFF, 0, 197);
    n_tests++;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL len0_latency o_valid=%b want 1", o_valid); end
    wait_result(c, k, ok);
    n_tests++;
    if (!ok || c != 1 || k != 0) begin n_fail++; $display("FAIL len0_result got %0d/%0d want 1/0", c, k); end
    n_tests++;
    if (mv_cycles != mv0) begin n_fail++; $display("FAIL len0_mvalid got %0d cycles want 0", mv_cycles - mv0); end
  endtask

  task automatic test_backpressure();
    int c, k; bit ok;
    m_stall = 4;
    start_job(132, 5, 3, 2, 197);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (m_valid !== 1'b1 || m_a !== 8'd132 || m_b !== 8'd5) begin
        n_fail++; $display("FAIL mstall_%0d v=%b a=%0d b=%0d want 1/132/5", i, m_valid, m_a, m_b);
      end
      @(negedge clk);
    end
    ok = 0;
    for (int w = 0; w < 3000; w++) begin
      if (o_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL bp_timeout o_valid never rose want 1"); end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (o_valid !== 1'b1 || o_crypto !== 8'd125 || i_ready !== 1'b0) begin
        n_fail++; $display("FAIL ostall_%0d v=%b crypto=%0d i_ready=%b want 1/125/0", i, o_valid, o_crypto, i_ready);
      end
      @(negedge clk);
    end
    wait_result(c, k, ok);
    n_tests++;
    if (!ok || c != 125 || k != 4) begin n_fail++; $display("FAIL bp_result got %0d/%0d want 125/4", c, k); end
  endtask

  task automatic test_reset_mid();
    int c, k; bit ok;
    start_job(132, 5, 8'h0D, 4, 197);
    ok = 0;
    for (int w = 0; w < 200; w++) begin
      if (r_ready && o_op_count == 2) begin ok = 1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL mul_wait_reach got 0 want 1"); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({i_ready, o_valid, m_valid, r_ready} !== 4'b1000 ||
        {o_crypto, o_op_count, m_a, m_b, m_mod} !== '0) begin
      n_fail++;
      $display("FAIL midrst ctrl=%b crypto=%0d cnt=%0d a=%0d mod=%0d want 1000/0",
               {i_ready, o_valid, m_valid, r_ready}, o_crypto, o_op_count, m_a, m_mod);
    end
    @(negedge clk);
    rst = 1'b0;
    start_job(132, 5, 3, 2, 197);
    wait_result(c, k, ok);
    n_tests++;
    if (!ok || c != 125 || k != 4) begin n_fail++; $display("FAIL after_rst got %0d/%0d want 125/4", c, k); end
  endtask

  task automatic test_random();
    int n, base, msg, key, len, c, k, want; bit ok;
    for (int j = 0; j < 20; j++) begin
      n    = $urandom_range(1, 127) * 2 + 1;
      base = 65536 % n;
      msg  = $urandom_range(0, n - 1);
      key  = $urandom_range(0, 255);
      len  = $urandom_range(0, 15);
      m_stall = $urandom_range(0, 2);
      want = modpow(msg, eff_key(key, len), n);
      start_job(base, msg, key, len, n);
      wait_result(c, k, ok);
      n_tests++;
      if (!ok || c != want || k != exp_ops(key, len)) begin
        n_fail++;
        $display("FAIL rand%0d n=%0d msg=%0d key=%0d len=%0d got %0d/%0d want %0d/%0d",
                 j, n, msg, key, len, c, k, want, exp_ops(key, len));
      end
    end
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0;
    i_base = '0; i_msg = '0; i_key = '0; i_exp_len = '0; i_modulus = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_basic();
    test_op_order();
    test_clamp();
    test_len_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
